// File: rtl/rotor_shift_pkg.sv
// rtl/rotor_shift_pkg.sv - shared constants, character classes and modular helpers for the rotor shift pipe
package rotor_shift_pkg;

  localparam int ALPHA_LEN = 26;
  localparam int DIGIT_LEN = 10;

  localparam logic [7:0] BASE_UPPER = 8'd65;
  localparam logic [7:0] BASE_LOWER = 8'd97;
  localparam logic [7:0] BASE_DIGIT = 8'd48;

  localparam logic [5:0] ALPHA_LEN6 = 6'(ALPHA_LEN);
  localparam logic [5:0] DIGIT_LEN6 = 6'(DIGIT_LEN);

  typedef enum logic [1:0] {
    CC_UPPER,
    CC_LOWER,
    CC_DIGIT,
    CC_OTHER
  } char_class_e;

  function automatic char_class_e classify(input logic [7:0] c);
    if (c >= 8'd65 && c <= 8'd90) return CC_UPPER;
    if (c >= 8'd97 && c <= 8'd122) return CC_LOWER;
    if (c >= 8'd48 && c <= 8'd57) return CC_DIGIT;
    return CC_OTHER;
  endfunction

  // off and k are both already below m, so one conditional correction suffices
  function automatic logic [5:0] shift_mod(input logic [5:0] off, input logic [5:0] k,
                                           input logic dec, input logic [5:0] m);
    logic [5:0] s;
    if (!dec) begin
      s = off + k;
      if (s >= m) s = s - m;
    end else if (off >= k) begin
      s = off - k;
    end else begin
      s = off + m - k;
    end
    return s;
  endfunction

  function automatic logic [4:0] reduce26(input logic [5:0] v);
    return (v >= ALPHA_LEN6) ? 5'(v - ALPHA_LEN6) : v[4:0];
  endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// rtl/pipe_elastic_stage.sv - one valid/ready register stage that refills in the cycle it drains
module pipe_elastic_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/rotor_shift_pipe.sv
// rtl/rotor_shift_pipe.sv - elastic Caesar shift stage with a rotating key and configurable pipeline depth
module rotor_shift_pipe
  import rotor_shift_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter bit DIGITS_EN  = 1'b1,
  parameter int ROT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [4:0]       cfg_key,
  input  logic [4:0]       cfg_step,
  input  logic [ROT_W-1:0] cfg_rot_freq,
  input  logic             cfg_mode,
  input  logic             cfg_shift_en,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic [4:0]       cur_key,
  output logic             busy
);

  logic [4:0]       key_q, key_d;
  logic [4:0]       step_q, step_d;
  logic [ROT_W-1:0] freq_q, freq_d;
  logic [ROT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             en_q, en_d;

  char_class_e cc;
  logic [5:0]  key6, kd6, off6, res6;
  logic [7:0]  base8, xf_data;
  logic        accept, counting;

  assign cc     = classify(s_data);
  assign accept = s_valid && s_ready;
  assign counting = accept && en_q &&
                    ((cc == CC_UPPER) || (cc == CC_LOWER) || (DIGITS_EN && (cc == CC_DIGIT)));

  always_comb begin
    key6 = {1'b0, key_q};
    if (key6 >= 6'd20)      kd6 = key6 - 6'd20;
    else if (key6 >= 6'd10) kd6 = key6 - 6'd10;
    else                    kd6 = key6;
    base8   = BASE_DIGIT;
    off6    = '0;
    res6    = '0;
    xf_data = s_data;
    case (cc)
      CC_UPPER, CC_LOWER: begin
        base8   = (cc == CC_UPPER) ? BASE_UPPER : BASE_LOWER;
        off6    = 6'(s_data - base8);
        res6    = shift_mod(off6, key6, mode_q, ALPHA_LEN6);
        xf_data = base8 + {2'b00, res6};
      end
      CC_DIGIT: begin
        if (DIGITS_EN) begin
          off6    = 6'(s_data - BASE_DIGIT);
          res6    = shift_mod(off6, kd6, mode_q, DIGIT_LEN6);
          xf_data = BASE_DIGIT + {2'b00, res6};
        end
      end
      default: ;
    endcase
    if (!en_q) xf_data = s_data;
  end

  // cfg_load overrides any rotation caused by a beat accepted in the same cycle
  always_comb begin
    key_d  = key_q;
    step_d = step_q;
    freq_d = freq_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    en_d   = en_q;
    if (counting && (freq_q != '0)) begin
      if (cnt_q == freq_q - ROT_W'(1)) begin
        cnt_d = '0;
        key_d = reduce26({1'b0, key_q} + {1'b0, step_q});
      end else begin
        cnt_d = cnt_q + ROT_W'(1);
      end
    end
    if (cfg_load) begin
      key_d  = reduce26({1'b0, cfg_key});
      step_d = reduce26({1'b0, cfg_step});
      freq_d = cfg_rot_freq;
      cnt_d  = '0;
      mode_d = cfg_mode;
      en_d   = cfg_shift_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      step_q <= '0;
      freq_q <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      key_q  <= key_d;
      step_q <= step_d;
      freq_q <= freq_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      en_q   <= en_d;
    end
  end

  logic                  vld [PIPE_DEPTH+1];
  logic                  rdy [PIPE_DEPTH+1];
  logic [7:0]            dat [PIPE_DEPTH+1];
  logic [PIPE_DEPTH-1:0] stage_valid;

  assign vld[0]          = s_valid;
  assign dat[0]          = xf_data;
  assign s_ready         = rdy[0];
  assign rdy[PIPE_DEPTH] = m_ready;
  assign m_valid         = vld[PIPE_DEPTH];
  assign m_data          = dat[PIPE_DEPTH];
  assign cur_key         = key_q;
  assign busy            = |stage_valid;

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
    pipe_elastic_stage #(.W(8)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (vld[i]),
      .in_data_i  (dat[i]),
      .in_ready_o (rdy[i]),
      .out_valid_o(vld[i+1]),
      .out_ready_i(rdy[i+1]),
      .out_data_o (dat[i+1])
    );
    assign stage_valid[i] = vld[i+1];
  end

endmodule

// File: tb/tb_rotor_shift_pipe.sv
// tb/tb_rotor_shift_pipe.sv - directed scoreboard bench for rotor_shift_pipe
module tb_rotor_shift_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [4:0] cfg_key, cfg_step;
  logic [2:0] cfg_rot_freq;
  logic       cfg_mode, cfg_shift_en;
  logic       s_valid, s_ready, m_valid, m_ready, busy;
  logic [7:0] s_data, m_data;
  logic [4:0] cur_key;

  always #5 clk = ~clk;

  rotor_shift_pipe #(.PIPE_DEPTH(2), .DIGITS_EN(1'b1), .ROT_W(3)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_step(cfg_step),
    .cfg_rot_freq(cfg_rot_freq), .cfg_mode(cfg_mode), .cfg_shift_en(cfg_shift_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cur_key(cur_key), .busy(busy)
  );

  typedef struct { logic [7:0] exp; int acc; } sb_t;
  sb_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int popped = 0;
  int bp_base = 0;
  bit lat_chk = 1'b1;
  bit mon_en  = 1'b1;
  bit bp_on   = 1'b0;
  bit bp_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] c, input int key, input bit dec);
    int k;
    if (c >= 8'd65 && c <= 8'd90) begin
      k = dec ? 26 - (key % 26) : key % 26;
      return 8'(65 + ((int'(c) - 65 + k) % 26));
    end
    if (c >= 8'd97 && c <= 8'd122) begin
      k = dec ? 26 - (key % 26) : key % 26;
      return 8'(97 + ((int'(c) - 97 + k) % 26));
    end
    if (c >= 8'd48 && c <= 8'd57) begin
      k = dec ? 10 - (key % 10) : key % 10;
      return 8'(48 + ((int'(c) - 48 + k) % 10));
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (mon_en && m_valid) begin
      chk("unexpected_beat", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        if (m_ready) begin
          sb_t e;
          e = sb.pop_front();
          chk("m_data", 32'(m_data), 32'(e.exp));
          if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd2);
          popped++;
        end else begin
          chk("stall_hold", 32'(m_data), 32'(sb[0].exp));
        end
      end
    end
  end

  task automatic upd_mready();
    if (bp_on) m_ready = !((cyc - bp_base) >= 3 && (cyc - bp_base) <= 7);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    upd_mready();
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] e, input bit push);
    bit done;
    done = 1'b0;
    s_valid = 1'b1;
    s_data  = c;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (bp_on && !s_ready) bp_stall = 1'b1;
      if (s_ready) begin
        if (push) sb.push_back('{exp: e, acc: cyc});
        done = 1'b1;
      end
      step();
    end
    s_valid = 1'b0;
    if (!done) chk("s_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic cfg(input int key, input int stp, input int freq, input bit mode, input bit en);
    cfg_key      = 5'(key);
    cfg_step     = 5'(stp);
    cfg_rot_freq = 3'(freq);
    cfg_mode     = mode;
    cfg_shift_en = en;
    cfg_load     = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    for (int t = 0; t < 60 && sb.size() != 0; t++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    rst = 1'b1; cfg_load = 1'b0; cfg_key = '0; cfg_step = '0; cfg_rot_freq = '0;
    cfg_mode = 1'b0; cfg_shift_en = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_cur_key", 32'(cur_key), 32'd0);

    // after reset shift_en is 0, so data passes unchanged
    send("q", "q", 1'b1);
    drain();

    cfg(3, 0, 0, 1'b0, 1'b1);
    send("A", 8'd68, 1'b1);
    send("z", 8'd99, 1'b1);
    send("7", 8'd48, 1'b1);
    send(" ", 8'd32, 1'b1);
    drain();

    cfg(3, 0, 0, 1'b1, 1'b1);
    send("D", 8'd65, 1'b1);
    send("a", 8'd120, 1'b1);
    send("2", 8'd57, 1'b1);
    drain();

    cfg(11, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      c = 8'($urandom_range(32, 126));
      send(c, ref_shift(c, 11, 1'b0), 1'b1);
    end
    cfg(23, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      c = 8'($urandom_range(32, 126));
      send(c, ref_shift(c, 23, 1'b1), 1'b1);
    end
    drain();

    cfg(1, 1, 2, 1'b0, 1'b1);
    send("A", "B", 1'b1);
    send("A", "B", 1'b1);
    send("A", "C", 1'b1);
    send("A", "C", 1'b1);
    drain();
    chk("rotor_key_aaaa", 32'(cur_key), 32'd3);
    cfg(1, 1, 2, 1'b0, 1'b1);
    send("A", "B", 1'b1);
    send(" ", " ", 1'b1);
    send("A", "B", 1'b1);
    drain();
    chk("rotor_key_space", 32'(cur_key), 32'd2);

    cfg(5, 1, 1, 1'b0, 1'b0);
    send("A", "A", 1'b1);
    send("5", "5", 1'b1);
    drain();
    chk("bypass_key", 32'(cur_key), 32'd5);

    cfg(3, 0, 0, 1'b0, 1'b1);
    lat_chk = 1'b0;
    popped = 0;
    bp_stall = 1'b0;
    bp_base = cyc;
    bp_on = 1'b1;
    upd_mready();
    for (int i = 0; i < 10; i++) send(8'h41 + 8'(i), ref_shift(8'h41 + 8'(i), 3, 1'b0), 1'b1);
    drain();
    bp_on = 1'b0;
    m_ready = 1'b1;
    lat_chk = 1'b1;
    chk("bp_s_ready_dropped", 32'(bp_stall), 32'd1);
    chk("bp_count", 32'(popped), 32'd10);

    cfg(25, 0, 0, 1'b0, 1'b1);
    send("Z", "Y", 1'b1);
    drain();
    cfg(0, 30, 1, 1'b0, 1'b1);
    send("A", "A", 1'b1);
    drain();
    chk("step_reduced", 32'(cur_key), 32'd4);
    cfg(25, 1, 1, 1'b0, 1'b1);
    send("A", "Z", 1'b1);
    drain();
    chk("key_wrap", 32'(cur_key), 32'd0);

    cfg(5, 1, 2, 1'b0, 1'b1);
    send("A", "F", 1'b1);
    s_valid = 1'b1; s_data = "A";
    cfg_key = 5'd10; cfg_step = 5'd1; cfg_rot_freq = 3'd2; cfg_mode = 1'b0; cfg_shift_en = 1'b1;
    cfg_load = 1'b1;
    @(negedge clk);
    chk("load_accept_ready", 32'(s_ready), 32'd1);
    sb.push_back('{exp: "F", acc: cyc});
    step();
    s_valid = 1'b0;
    cfg_load = 1'b0;
    chk("load_wins_key", 32'(cur_key), 32'd10);
    send("A", "K", 1'b1);
    drain();
    chk("load_clears_cnt", 32'(cur_key), 32'd10);
    send("A", "K", 1'b1);
    drain();
    chk("rotor_after_load", 32'(cur_key), 32'd11);

    mon_en = 1'b0;
    m_ready = 1'b0;
    send("A", 8'd0, 1'b0);
    send("B", 8'd0, 1'b0);
    chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cur_key", 32'(cur_key), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    repeat (6) step();
    chk("post_rst_silent", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
